// File: rtl/sweep_pkg.sv
// Shared state encoding and MISR constants for the exhaustive sweep/capture block.
package sweep_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } sweep_state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/sweep_fifo.sv
// Synchronous power-of-two FIFO with full/empty flags; head data is visible one cycle after the write.
// A write while full is taken only together with a read in the same cycle.
module sweep_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic             CK,
   input  logic             reset,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_rdy,
   output logic             rd_vld,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_fire;
   logic             rd_fire;

   // The extra pointer MSB separates a wrapped (full) state from an empty one.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_vld  = !empty;
   assign rd_fire = rd_vld && rd_rdy;
   assign wr_fire = wr_vld && (!full || rd_fire);
   assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_fire) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge CK) begin
      if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end

endmodule

// File: rtl/exhaustive_sweep_capture.sv
// Drives all 2^N_W patterns in order, samples resp_i after SETTLE cycles, queues {pattern,response} records;
// stalls in SAMPLE while the record FIFO is full. Optional MISR signature on sig_o with SWEEP_MISR_EN.
module exhaustive_sweep_capture
   import sweep_pkg::*;
#(
   parameter int N_W    = 4,
   parameter int R_W    = 1,
   parameter int SETTLE = 1,
   parameter int DEPTH  = 4
) (
   input  logic           CK,
   input  logic           reset,
   input  logic           start,
   output logic [N_W-1:0] pat_o,
   input  logic [R_W-1:0] resp_i,
   output logic           busy,
   output logic           done,
   output logic           rec_valid,
   input  logic           rec_ready,
   output logic [N_W-1:0] rec_pat,
   output logic [R_W-1:0] rec_resp
`ifdef SWEEP_MISR_EN
   ,
   output logic [15:0]    sig_o
`endif
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   sweep_state_t       state;
   sweep_state_t       state_nxt;
   logic [N_W-1:0]     pat_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               push;
   logic               seed;
   logic               fifo_full;
   logic               fifo_empty;
   logic [N_W+R_W-1:0] head_dat;

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         pat_o <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         pat_o <= pat_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pat_nxt   = pat_o;
      cnt_nxt   = cnt;
      push      = 1'b0;
      seed      = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt = S_DRIVE;
               pat_nxt   = '0;
               cnt_nxt   = '0;
               seed      = 1'b1;
            end
         end
         S_DRIVE: begin
            if (cnt == CNT_W'(SETTLE - 1)) state_nxt = S_SAMPLE;
            else                           cnt_nxt   = cnt + CNT_W'(1);
         end
         S_SAMPLE: begin
            // A full FIFO still takes the record if its head leaves this cycle.
            push = !fifo_full || (rec_valid && rec_ready);
            if (push) begin
               if (&pat_o) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_DRIVE;
                  pat_nxt   = pat_o + N_W'(1);
                  cnt_nxt   = '0;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
   assign done = (state == S_DONE);

   sweep_fifo #(
      .WIDTH (N_W + R_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CK     (CK),
      .reset  (reset),
      .wr_vld (push),
      .wr_dat ({pat_o, resp_i}),
      .rd_rdy (rec_ready),
      .rd_vld (rec_valid),
      .rd_dat (head_dat),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign {rec_pat, rec_resp} = head_dat;

`ifdef SWEEP_MISR_EN
   logic [15:0] sig;

   always_ff @(posedge CK or posedge reset) begin
      if (reset)     sig <= MISR_SEED;
      else if (seed) sig <= MISR_SEED;
      else if (push) sig <= {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ 16'(resp_i);
   end

   assign sig_o = sig;
`endif

endmodule

// File: tb/tb_exhaustive_sweep_capture.sv
`timescale 1ns/1ps
module tb_exhaustive_sweep_capture;

   logic CK = 1'b0;
   logic reset;
   always #5 CK = ~CK;

   // SETTLE=1 instance
   logic       start1, busy1, done1, rv1, rr1, rres1, resp1;
   logic [3:0] pat1, rp1;
   logic [15:0] sig1;
   // SETTLE=3 instance, response delayed two cycles
   logic       start3, busy3, done3, rv3, rr3, rres3, resp3;
   logic [3:0] pat3, rp3;
   logic [15:0] sig3;

   logic [15:0] lut1, lut3;
   logic [3:0]  d1, d2;

   assign resp1 = lut1[pat1];
   always @(posedge CK) begin
      d1 <= pat3;
      d2 <= d1;
   end
   assign resp3 = lut3[d2];

   exhaustive_sweep_capture #(.N_W(4), .R_W(1), .SETTLE(1), .DEPTH(4)) dut (
      .CK(CK), .reset(reset), .start(start1), .pat_o(pat1), .resp_i(resp1),
      .busy(busy1), .done(done1), .rec_valid(rv1), .rec_ready(rr1),
      .rec_pat(rp1), .rec_resp(rres1)
`ifdef SWEEP_MISR_EN
      , .sig_o(sig1)
`endif
   );

   exhaustive_sweep_capture #(.N_W(4), .R_W(1), .SETTLE(3), .DEPTH(4)) dut3 (
      .CK(CK), .reset(reset), .start(start3), .pat_o(pat3), .resp_i(resp3),
      .busy(busy3), .done(done3), .rec_valid(rv3), .rec_ready(rr3),
      .rec_pat(rp3), .rec_resp(rres3)
`ifdef SWEEP_MISR_EN
      , .sig_o(sig3)
`endif
   );

   logic [4:0] q1[$];
   logic [4:0] q3[$];
   int mode1, mode3;   // consumer ready: 0 low, 1 high, 2 random
   int passed = 0;
   int fails  = 0;
   int total  = 0;
   int n;
   logic [15:0] par, sig_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] par_lut();
      logic [15:0] l;
      for (int p = 0; p < 16; p++) begin
         logic [3:0] pv;
         pv   = 4'(p);
         l[p] = ^pv;
      end
      return l;
   endfunction

`ifdef SWEEP_MISR_EN
   function automatic logic [15:0] misr(input logic [15:0] l);
      logic [15:0] s;
      s = 16'hFFFF;
      for (int p = 0; p < 16; p++)
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, l[p]};
      return s;
   endfunction
`endif

   task automatic load1();
      for (int p = 0; p < 16; p++) q1.push_back({4'(p), lut1[p]});
   endtask

   task automatic load3();
      for (int p = 0; p < 16; p++) q3.push_back({4'(p), lut3[p]});
   endtask

   // One clock: choose ready for the coming edge, then score any record that edge pops.
   task automatic cyc();
      logic [31:0] e;
      @(negedge CK);
      rr1 = (mode1 == 2) ? 1'($urandom) : (mode1 == 1);
      rr3 = (mode3 == 2) ? 1'($urandom) : (mode3 == 1);
      if (rv1 && rr1) begin
         e = 'x;
         if (q1.size() > 0) e = {27'b0, q1.pop_front()};
         chk("rec1", {27'b0, rp1, rres1}, e);
      end
      if (rv3 && rr3) begin
         e = 'x;
         if (q3.size() > 0) e = {27'b0, q3.pop_front()};
         chk("rec3", {27'b0, rp3, rres3}, e);
      end
   endtask

   task automatic run1_to_end(input string tag);
      n = 0;
      while ((!done1 || q1.size() > 0) && n < 1000) begin
         cyc();
         n++;
      end
      chk({tag, "_timeout"}, 32'(n < 1000), 32'd1);
      repeat (2) cyc();
      chk({tag, "_drained"}, 32'(rv1), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      start1 = 1'b0; start3 = 1'b0;
      rr1 = 1'b0; rr3 = 1'b0;
      mode1 = 1; mode3 = 1;
      par  = par_lut();
      lut1 = par;
      lut3 = 16'h0;
      repeat (2) cyc();
      chk("rst_pat",   32'(pat1),  32'd0);
      chk("rst_busy",  32'(busy1), 32'd0);
      chk("rst_done",  32'(done1), 32'd0);
      chk("rst_valid", 32'(rv1),   32'd0);
      chk("rst_rec",   32'({rp1, rres1}), 32'd0);
      chk("rst_valid3", 32'(rv3),  32'd0);
`ifdef SWEEP_MISR_EN
      chk("rst_sig", 32'(sig1), 32'hFFFF);
`endif
      reset = 1'b0;
      cyc();

      // Basic sweep with parity responses
      load1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      chk("start_pat0", 32'(pat1),  32'd0);
      chk("start_busy", 32'(busy1), 32'd1);
      n = 1;
      while (!done1 && n < 200) begin
         cyc();
         n++;
      end
      chk("done_cycle",   32'(n),     32'd33);
      chk("busy_at_done", 32'(busy1), 32'd0);
      repeat (3) cyc();
      chk("basic_drained", 32'(q1.size()), 32'd0);
`ifdef SWEEP_MISR_EN
      chk("sig_model", 32'(sig1), 32'(misr(lut1)));
      chk("sig_not_seed", 32'(sig1 == 16'hFFFF), 32'd0);
      sig_a = sig1;
`endif

      // Backpressure, then random drain with an ignored start mid-sweep
      mode1 = 0;
      lut1 = 16'($urandom);
      load1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      repeat (40) cyc();
      chk("stall_pat",   32'(pat1),  32'd4);
      chk("stall_busy",  32'(busy1), 32'd1);
      chk("stall_valid", 32'(rv1),   32'd1);
      chk("stall_head",  32'({rp1, rres1}), 32'({4'd0, lut1[0]}));
      mode1 = 2;
      repeat (10) cyc();
      chk("busy_before_start", 32'(busy1), 32'd1);
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      run1_to_end("bp");
`ifdef SWEEP_MISR_EN
      chk("sig_model2", 32'(sig1), 32'(misr(lut1)));
`endif

      // Repeat parity sweep, then parity with pattern 1010 flipped
      lut1 = par;
      load1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      run1_to_end("rep");
`ifdef SWEEP_MISR_EN
      chk("sig_repeat", 32'(sig1), 32'(sig_a));
`endif
      lut1 = par ^ 16'h0400;
      load1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      run1_to_end("flip");
`ifdef SWEEP_MISR_EN
      chk("sig_flip_model", 32'(sig1), 32'(misr(lut1)));
      chk("sig_flip_differs", 32'(sig1 != sig_a), 32'd1);
`endif

      // Reset during pattern 0110 with two records queued
      mode1 = 1;
      lut1 = 16'($urandom);
      load1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      n = 0;
      while (pat1 != 4'd4 && n < 100) begin
         cyc();
         n++;
      end
      mode1 = 0;
      while (pat1 != 4'd6 && n < 100) begin
         cyc();
         n++;
      end
      chk("mid_timeout", 32'(n < 100), 32'd1);
      chk("mid_queued_head", 32'(rp1), 32'd4);
      reset = 1'b1;
      #1;
      chk("mid_rst_pat",   32'(pat1),  32'd0);
      chk("mid_rst_busy",  32'(busy1), 32'd0);
      chk("mid_rst_valid", 32'(rv1),   32'd0);
      q1.delete();
      cyc();
      reset = 1'b0;
      mode1 = 1;
      load1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      n = 0;
      while (!rv1 && n < 20) begin
         cyc();
         n++;
      end
      chk("first_after_reset", 32'({rv1, rp1}), 32'({1'b1, 4'd0}));
      run1_to_end("post_rst");

      // SETTLE=3 with delayed response
      lut3 = 16'($urandom);
      load3();
      start3 = 1'b1;
      cyc();
      start3 = 1'b0;
      chk("s3_pat_c1", 32'(pat3), 32'd0);
      n = 1;
      while (!done3 && n < 400) begin
         cyc();
         n++;
         if (n == 4) chk("s3_pat_c4", 32'(pat3), 32'd0);
         if (n == 5) chk("s3_pat_c5", 32'(pat3), 32'd1);
      end
      chk("s3_done_cycle", 32'(n), 32'd65);
      repeat (3) cyc();
      chk("s3_drained", 32'(q3.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/exhaustive_sweep_capture.md
# exhaustive_sweep_capture

Synthesizable on-chip replacement for the per-benchmark exhaustive-input testbenches. It drives every one of the 2^N_W input patterns onto a device under test in ascending order, waits a programmable settle time, and samples the response. Each (pattern, response) record is pushed into a ready/valid readout FIFO, and the sweep stalls under backpressure. It sits between the DUT wrapper and the trojan-detection data-collection path, replacing per-benchmark text-file dumps.

## Interface
Parameters:
- N_W, 4, DUT input width; 1..16.
- R_W, 1, DUT response width; 1..16.
- SETTLE, 1, cycles each pattern is held before sampling; ≥1.
- DEPTH, 4, record FIFO depth; power of two, ≥2.

Ports:
- CK  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- pat_o  out  N_W  pattern driven to the DUT.
- resp_i  in  R_W  DUT response.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  high in DONE.
- rec_valid  out  1  FIFO non-empty.
- rec_ready  in  1  consumer accepts the head record.
- rec_pat  out  N_W  pattern field of the head record.
- rec_resp  out  R_W  response field of the head record.
- sig_o  out  16  MISR signature; present only with SWEEP_MISR_EN.

## Operation
- FSM states are IDLE, DRIVE, SAMPLE and DONE.
- IDLE or DONE with start=1 → DRIVE. pat_o is cleared to 0, the settle counter is cleared, and the MISR is seeded.
- DRIVE: pat_o is held and the counter counts SETTLE cycles. DRIVE → SAMPLE when the count reaches SETTLE−1.
- SAMPLE: {pat_o, resp_i} is pushed if the FIFO is not full. If the FIFO is full, the FSM stays in SAMPLE with pat_o held and retries every cycle.
- After a successful push, if pat_o is all-ones → DONE. Otherwise pat_o increments by 1 and the FSM returns to DRIVE.
- DONE is held until the next start.
- start in DRIVE or SAMPLE is ignored.
- FIFO pop happens on rec_valid & rec_ready.
- Push and pop in the same cycle are both allowed when full: push and pop both proceed, and the occupancy is unchanged.
- The FIFO is not flushed by start. Records from a previous sweep drain first, in order.
- Read and write pointers are log2(DEPTH)+1 bits wide, and the extra MSB distinguishes full from empty.
- Pattern wrap-around: there is no increment past all-ones. Exactly 2^N_W records are produced per sweep.

## Timing
- Reset values:
  - state is IDLE.
  - pat_o, busy, done, rec_valid, rec_pat and rec_resp are all 0.
  - the FIFO is empty.
  - sig_o is 16'hFFFF.
- start sampled at edge k → DRIVE from cycle k+1, with pat_o=0 visible from k+1.
- Unstalled cost is SETTLE+1 cycles per pattern. resp_i is captured on the SAMPLE-cycle edge.
- A pushed record shows rec_valid on the next cycle (1-cycle latency). rec_pat/rec_resp are stable while rec_valid & !rec_ready.
- done rises the cycle after the final push. busy falls in that same cycle.
- Reset mid-sweep aborts immediately. All state returns to reset values, and queued records are discarded.

## Configuration
- SWEEP_MISR_EN defined:
  - a 16-bit Galois MISR with polynomial 16'h1021 and seed 16'hFFFF.
  - it updates on every successful push: sig = (sig<<1) ^ (sig[15] ? POLY : 0) ^ zero-extended resp_i.
  - sig_o is stable while in DONE.
- SWEEP_MISR_EN not defined: no MISR logic and no sig_o port.

## Structure
- Package sweep_pkg holds:
  - the state enum type.
  - MISR_POLY = 16'h1021.
  - MISR_SEED = 16'hFFFF.
- Sub-module sweep_fifo is a parametrised synchronous FIFO (width N_W+R_W, depth DEPTH) with full and empty flags. It is instantiated once.

## Test plan
- Basic sweep: N_W=4, R_W=1, SETTLE=1, resp_i = ^pat_o, rec_ready=1, start at cycle 0.
  - Required: 16 records 0000/0, 0001/1, 0010/1, …, 1111/0, in order.
  - done high from cycle 33.
- Backpressure: rec_ready=0 throughout.
  - Required: after 4 pushes the FSM stalls in SAMPLE with pat_o=0100 and busy=1.
  - Then set rec_ready=1. Required: all 16 records arrive with no loss or duplication.
- Settle time: SETTLE=3 with resp_i driven from pat_o through a 2-cycle delay.
  - Required: every record has rec_resp matching its own rec_pat.
  - Each pattern takes 4 cycles.
- Reset mid-sweep: assert reset during pattern 0110 with 2 records queued.
  - Required: immediately pat_o=0, busy=0 and rec_valid=0.
  - Then start again. Required: the first record is 0000.
- Ignored start: pulse start while busy.
  - Required: the sweep is not restarted and the record sequence is unbroken.
- Signature (SWEEP_MISR_EN): two sweeps with the same resp_i function.
  - Required: identical sig_o, not equal to 16'hFFFF.
  - Flip the response for pattern 1010 only. Required: sig_o differs.
